alu_iter: RTL and testbench

Parametrised successor to the datapath ALU. It keeps the single-cycle arithmetic, logic, compare and shift operations, registers their result, and adds iterative multiply and divide that write HI/LO registers. It sits in the execute stage; a start/busy/done handshake lets the control unit stall on multi-cycle operations.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/muldiv_iter.sv | 150 +++++++++++++++
 rtl/alu_iter.sv | 111 +++++++++++
 tb/tb_alu_iter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and decode helper for the iterative ALU.
// ALU_DIV_EN enables the divide opcodes; without it they decode as undefined.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return op[3:2] == 2'b11;
`else
    return op[3:1] == 3'b110;
`endif
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with magnitude and sign fixup.
// The divider datapath exists only when ALU_DIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
`ifdef ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic             signed_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*Width-1:0]   p_q, p_d;
  logic [Width-1:0]     b_q, b_d;
  logic                 neg_q, neg_d;
  logic [Width-1:0]     hi_q, hi_d;
  logic [Width-1:0]     lo_q, lo_d;

  logic [Width-1:0]     a_mag, b_mag;
  logic [Width:0]       mul_sum;
  logic [2*Width-1:0]   mul_step;
  logic [2*Width-1:0]   p_neg;

  assign a_mag = (signed_i && a_i[Width-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[Width-1]) ? -b_i : b_i;

  // {hi, lo} holds partial product above the not-yet-consumed multiplier bits
  assign mul_sum  = {1'b0, p_q[2*Width-1:Width]} + (p_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, p_q[Width-1:1]};
  assign p_neg    = -p_q;

`ifdef ALU_DIV_EN
  logic               div_q, div_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [Width:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*Width-1:0] div_step;

  // Upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign div_sh   = {p_q[2*Width-1:Width], p_q[Width-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = ~div_diff[Width];
  assign div_step = {(div_ge ? div_diff[Width-1:0] : div_sh[Width-1:0]), p_q[Width-2:0], div_ge};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    b_d     = b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef ALU_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          state_d = StRun;
          cnt_d   = '0;
          p_d     = {{Width{1'b0}}, a_mag};
          b_d     = b_mag;
          neg_d   = signed_i & (a_i[Width-1] ^ b_i[Width-1]);
`ifdef ALU_DIV_EN
          div_d   = div_i;
          rneg_d  = signed_i & a_i[Width-1];
          dz_d    = (b_i == '0);
`endif
        end
      end
      StRun: begin
        p_d   = mul_step;
`ifdef ALU_DIV_EN
        if (div_q) p_d = div_step;
`endif
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        {hi_d, lo_d} = neg_q ? p_neg : p_q;
`ifdef ALU_DIV_EN
        if (div_q) begin
          hi_d = rneg_q ? -p_q[2*Width-1:Width] : p_q[2*Width-1:Width];
          lo_d = neg_q ? -p_q[Width-1:0] : p_q[Width-1:0];
          // Divide by zero reports all-ones quotient regardless of operand signs
          if (dz_q) lo_d = '1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef ALU_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy_o = (state_q != StIdle);
  // Completion strobe: hi/lo load on the edge that ends this cycle
  assign done_o = (state_q == StFix);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: registered single-cycle ops plus iterative multiply/divide.
// Divide support is compiled in only when ALU_DIV_EN is defined.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bus_a_i,
  input  logic [WIDTH-1:0] bus_b_i,
  input  logic [WIDTH-1:0] extend_i,
  input  logic             alu_src_i,
  input  logic [3:0]       alu_ctr_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [WIDTH-1:0] op_b;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;
  logic             multi, issue;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic [WIDTH-1:0] res_q, res_d;
  logic             sel_lo_q, sel_lo_d;
  logic             done_q, done_d;

  assign op_b  = alu_src_i ? extend_i : bus_b_i;
  assign shamt = op_b[ShW-1:0];
  assign multi = is_multicycle(alu_ctr_i);
  assign issue = start_i & ~md_busy;

  always_comb begin
    alu_out = '0;
    case (alu_ctr_i)
      OP_ADD:  alu_out = bus_a_i + op_b;
      OP_SUB:  alu_out = bus_a_i - op_b;
      OP_AND:  alu_out = bus_a_i & op_b;
      OP_OR:   alu_out = bus_a_i | op_b;
      OP_XOR:  alu_out = bus_a_i ^ op_b;
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus_a_i < op_b)};
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus_a_i) < $signed(op_b))};
      OP_SLL:  alu_out = bus_a_i << shamt;
      OP_SRL:  alu_out = bus_a_i >> shamt;
      OP_SRA:  alu_out = $signed(bus_a_i) >>> shamt;
      default: alu_out = '0;
    endcase
  end

  muldiv_iter #(
    .Width(WIDTH)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .go_i     (issue & multi),
`ifdef ALU_DIV_EN
    .div_i    (alu_ctr_i[1]),
`endif
    .signed_i (alu_ctr_i[0]),
    .a_i      (bus_a_i),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  // Engine completion and single-cycle issue are exclusive: busy is high during fixup
  always_comb begin
    res_d    = res_q;
    sel_lo_d = sel_lo_q;
    done_d   = 1'b0;
    if (md_done) begin
      sel_lo_d = 1'b1;
      done_d   = 1'b1;
    end else if (issue && !multi) begin
      res_d    = alu_out;
      sel_lo_d = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q    <= '0;
      sel_lo_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      res_q    <= res_d;
      sel_lo_q <= sel_lo_d;
      done_q   <= done_d;
    end
  end

  assign result_o = sel_lo_q ? md_lo : res_q;
  assign zero_o   = (result_o == '0);
  assign busy_o   = md_busy;
  assign done_o   = done_q;
  assign hi_o     = md_hi;
  assign lo_o     = md_lo;

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH = 32); divide vectors need ALU_DIV_EN.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_a = '0, bus_b = '0, extend = '0;
  logic        alu_src = 1'b0;
  logic [3:0]  alu_ctr = 4'b0000;
  logic        start = 1'b0;
  logic        busy, done, zero;
  logic [31:0] result, hi, lo;

  int n_chk = 0;
  int n_bad = 0;
  int lat;

  alu_iter #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus_a_i   (bus_a),
    .bus_b_i   (bus_b),
    .extend_i  (extend),
    .alu_src_i (alu_src),
    .alu_ctr_i (alu_ctr),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .zero_o    (zero),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns #1 after the issuing edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] ext);
    @(negedge clk);
    alu_ctr = op;
    bus_a   = a;
    bus_b   = b;
    alu_src = src;
    extend  = ext;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done (bounded); optionally pulse an add start at cycle inject
  task automatic wait_done(input int inject, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == inject) begin
        alu_ctr = 4'b0010;
        bus_a   = 32'd1;
        bus_b   = 32'd1;
        alu_src = 1'b0;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0010, 32'd5, 32'd7, 1'b0, 32'd0);
    check_eq("add_res", result, 32'd12);
    check_eq("add_done", {31'd0, done}, 32'd1);
    check_eq("add_zero", {31'd0, zero}, 32'd0);
    check_eq("add_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("add_done_pulse", {31'd0, done}, 32'd0);

    issue(4'b0110, 32'd5, 32'hDEAD_BEEF, 1'b1, 32'd5);
    check_eq("sub_res", result, 32'd0);
    check_eq("sub_zero", {31'd0, zero}, 32'd1);

    issue(4'b1010, 32'h8000_0000, 32'd4, 1'b0, 32'd0);
    check_eq("sra", result, 32'hF800_0000);
    issue(4'b1001, 32'h8000_0000, 32'd4, 1'b0, 32'd0);
    check_eq("srl", result, 32'h0800_0000);
    issue(4'b1000, 32'd1, 32'd33, 1'b0, 32'd0);
    check_eq("sll_mask", result, 32'h0000_0002);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    check_eq("slt", result, 32'd1);
    issue(4'b0101, 32'd3, 32'd4, 1'b0, 32'd0);
    check_eq("undef_res", result, 32'd0);
    check_eq("undef_done", {31'd0, done}, 32'd1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    check_eq("sltu", result, 32'd0);
    issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, 1'b0, 32'd0);
    check_eq("xor", result, 32'hFF00_0000);
    issue(4'b0001, 32'hF000_0000, 32'h0000_000F, 1'b0, 32'd0);
    check_eq("or", result, 32'hF000_000F);

    // mult -3 * 5 with an ignored add start at cycle 10
    issue(4'b1101, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'd0);
    check_eq("mult_busy", {31'd0, busy}, 32'd1);
    check_eq("mult_nodone", {31'd0, done}, 32'd0);
    wait_done(9, lat);
    check_eq("mult_lat", lat, 32'd33);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFF1);
    check_eq("mult_res", result, 32'hFFFF_FFF1);
    check_eq("mult_busy_end", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("mult_done_pulse", {31'd0, done}, 32'd0);

    issue(4'b0010, 32'd2, 32'd3, 1'b0, 32'd0);
    check_eq("add_after_res", result, 32'd5);
    check_eq("add_keeps_hi", hi, 32'hFFFF_FFFF);
    check_eq("add_keeps_lo", lo, 32'hFFFF_FFF1);

    // Reset in the middle of a multu
    issue(4'b1100, 32'h0001_2345, 32'h0000_0100, 1'b0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    check_eq("mrst_hi", hi, 32'd0);
    check_eq("mrst_lo", lo, 32'd0);
    check_eq("mrst_result", result, 32'd0);
    check_eq("mrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b1100, 32'd6, 32'd7, 1'b0, 32'd0);
    wait_done(-1, lat);
    check_eq("multu_lat", lat, 32'd33);
    check_eq("multu_lo", lo, 32'd42);
    check_eq("multu_hi", hi, 32'd0);
    check_eq("multu_res", result, 32'd42);

`ifdef ALU_DIV_EN
    issue(4'b1111, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
    wait_done(-1, lat);
    check_eq("div_lat", lat, 32'd33);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    issue(4'b1110, 32'd9, 32'd0, 1'b0, 32'd0);
    wait_done(-1, lat);
    check_eq("divz_lat", lat, 32'd33);
    check_eq("divz_lo", lo, 32'hFFFF_FFFF);
    check_eq("divz_hi", hi, 32'd9);

    issue(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
    wait_done(-1, lat);
    check_eq("divmin_lo", lo, 32'h8000_0000);
    check_eq("divmin_hi", hi, 32'd0);

    issue(4'b1110, 32'd100, 32'd7, 1'b0, 32'd0);
    wait_done(-1, lat);
    check_eq("divu_lo", lo, 32'd14);
    check_eq("divu_hi", hi, 32'd2);
    check_eq("divu_res", result, 32'd14);
`else
    issue(4'b1111, 32'd100, 32'd7, 1'b0, 32'd0);
    check_eq("nodiv_done", {31'd0, done}, 32'd1);
    check_eq("nodiv_busy", {31'd0, busy}, 32'd0);
    check_eq("nodiv_res", result, 32'd0);
    check_eq("nodiv_hi", hi, 32'd0);
    check_eq("nodiv_lo", lo, 32'd42);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
